rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources.
- Port A: main pipeline writeback. Default priority.
- Port B: multi-cycle unit writeback (mul/div, late loads).
- Valid/ready handshake on each source; the accepted write is registered and driven onto the register file's write/wr/wd inputs one cycle later.
- A starvation counter guarantees B forward progress.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_write_arbiter_if.sv | 39 +++
 rtl/rf_wb_prio_arb.sv | 45 ++++
 rtl/rf_write_arbiter.sv | 89 ++++++++
 tb/tb_rf_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and widths used by the write arbiter, the
// register file and the pipeline writeback stage.
package rf_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

  // Write payload; the index field is 'rd' because 'reg' is a reserved word
  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle for the register-file write arbiter: two valid/ready writeback
// sources plus the register-file write port and starvation status.
interface rf_write_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_wr;
  logic [DATA_W-1:0] rf_wd;
  logic              b_starved;

  // Arbiter side
  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output rf_write, rf_wr, rf_wd, b_starved
  );

  // Writeback sources and register file side
  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  rf_write, rf_wr, rf_wd, b_starved
  );

endinterface

// File: rtl/rf_wb_prio_arb.sv
// Fixed-priority grant (A over B) with a saturating starvation counter that
// forces B through after STARVE_LIMIT lost cycles.
module rf_wb_prio_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_ready_o,
  output logic b_ready_o,
  output logic sel_b_o,
  output logic b_starved_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_b;

  assign force_b     = (cnt_q == LIMIT_C);
  assign b_starved_o = force_b;

  // Readies never look at their own port's valid
  assign a_ready_o = !reset && !(b_valid_i && force_b);
  assign b_ready_o = !reset && (!a_valid_i || force_b);
  assign sel_b_o   = b_valid_i && b_ready_o;

  always_comb begin
    cnt_d = '0;
    if (b_valid_i && !b_ready_o) begin
      cnt_d = force_b ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: grants one of two writeback sources per
// cycle and registers the accepted write. Optional macro RF_WB_FWD_EN adds
// combinational forwarding of the committing write to two read indices.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned ADDR_W       = RF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] q1_reg,
  input  logic [ADDR_W-1:0] q2_reg,
  output logic              q1_hit,
  output logic              q2_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  localparam logic [ADDR_W-1:0] ZERO_REG_C = ADDR_W'(RF_ZERO_REG);

  logic a_ready, b_ready, sel_b, b_starved;
  logic acc_a;
  wr_t  win;

  logic write_q, write_d;
  wr_t  wr_q, wr_d;

  rf_wb_prio_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .a_valid_i   (bus.a_valid),
    .b_valid_i   (bus.b_valid),
    .a_ready_o   (a_ready),
    .b_ready_o   (b_ready),
    .sel_b_o     (sel_b),
    .b_starved_o (b_starved)
  );

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.b_starved = b_starved;

  assign acc_a = bus.a_valid && a_ready;
  assign win   = sel_b ? wr_t'{rd: bus.b_reg, data: bus.b_data}
                       : wr_t'{rd: bus.a_reg, data: bus.a_data};

  // Index/data hold when idle; only the enable drops
  always_comb begin
    write_d = 1'b0;
    wr_d    = wr_q;
    if (acc_a || sel_b) begin
      write_d = (win.rd != ZERO_REG_C);
      wr_d    = win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      write_q <= write_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.rf_write = write_q;
  assign bus.rf_wr    = wr_q.rd;
  assign bus.rf_wd    = wr_q.data;

`ifdef RF_WB_FWD_EN
  assign q1_hit   = write_q && (wr_q.rd == q1_reg) && (q1_reg != ZERO_REG_C);
  assign q2_hit   = write_q && (wr_q.rd == q2_reg) && (q2_reg != ZERO_REG_C);
  assign fwd_data = wr_q.data;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (STARVE_LIMIT=4).
module tb_rf_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rf_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef RF_WB_FWD_EN
  logic [AW-1:0] q1_reg, q2_reg;
  logic          q1_hit, q2_hit;
  logic [DW-1:0] fwd_data;
`endif

  rf_write_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef RF_WB_FWD_EN
    ,
    .q1_reg   (q1_reg),
    .q2_reg   (q2_reg),
    .q1_hit   (q1_hit),
    .q2_hit   (q2_hit),
    .fwd_data (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_reg   = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_reg   = '0;
    bus.b_data  = '0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd3;
    bus.a_data  = 32'h1234;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.a_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_a_ready cyc%0d: got %b want 0", i, bus.a_ready);
      end
      checks++;
      if (bus.b_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_b_ready cyc%0d: got %b want 0", i, bus.b_ready);
      end
      step();
    end
    checks++;
    if (bus.rf_write !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got write=%b wr=%0d wd=%h want 0/0/0",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    checks++;
    if (bus.b_starved !== 1'b0) begin
      errors++;
      $display("FAIL reset_b_starved: got %b want 0", bus.b_starved);
    end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_single_a();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd16;
    bus.a_data  = 32'hffff_ffff;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_a_ready: got %b want 1", bus.a_ready);
    end
    step();
    bus.a_valid = 1'b0;
    checks++;
    if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'd16 || bus.rf_wd !== 32'hffff_ffff) begin
      errors++;
      $display("FAIL single_a_write: got write=%b wr=%0d wd=%h want 1/16/ffffffff",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    step();
    checks++;
    if (bus.rf_write !== 1'b0 || bus.rf_wr !== 5'd16 || bus.rf_wd !== 32'hffff_ffff) begin
      errors++;
      $display("FAIL idle_hold: got write=%b wr=%0d wd=%h want 0/16/ffffffff",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_b_ready: got %b want 1", bus.b_ready);
    end
  endtask

  task automatic test_starvation();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd1;
    bus.a_data  = 32'h11;
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd7;
    bus.b_data  = 32'hbeef;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b1 || bus.b_starved !== 1'b0) begin
        errors++;
        $display("FAIL starve_wait cyc%0d: got b_ready=%b a_ready=%b starved=%b want 0/1/0",
                 i, bus.b_ready, bus.a_ready, bus.b_starved);
      end
      step();
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'd1 || bus.rf_wd !== 32'h11) begin
        errors++;
        $display("FAIL starve_a_write cyc%0d: got write=%b wr=%0d wd=%h want 1/1/11",
                 i, bus.rf_write, bus.rf_wr, bus.rf_wd);
      end
    end
    #1;
    checks++;
    if (bus.b_starved !== 1'b1 || bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL starve_force: got starved=%b b_ready=%b a_ready=%b want 1/1/0",
               bus.b_starved, bus.b_ready, bus.a_ready);
    end
    step();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'd7 || bus.rf_wd !== 32'hbeef) begin
      errors++;
      $display("FAIL starve_b_write: got write=%b wr=%0d wd=%h want 1/7/beef",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    checks++;
    if (bus.b_starved !== 1'b0) begin
      errors++;
      $display("FAIL starve_clear: got %b want 0", bus.b_starved);
    end
    bus.a_valid = 1'b0;
    step();
  endtask

  task automatic test_zero_reg();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd0;
    bus.a_data  = 32'hdead;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_a_ready: got %b want 1", bus.a_ready);
    end
    step();
    bus.a_valid = 1'b0;
    checks++;
    if (bus.rf_write !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'hdead) begin
      errors++;
      $display("FAIL zero_no_write: got write=%b wr=%0d wd=%h want 0/0/dead",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    step();
  endtask

  task automatic test_same_dest();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 32'h1;
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd5;
    bus.b_data  = 32'h2;
    #1;
    checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_grant_a: got a_ready=%b b_ready=%b want 1/0",
               bus.a_ready, bus.b_ready);
    end
    step();
    bus.a_valid = 1'b0;
    checks++;
    if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'h1) begin
      errors++;
      $display("FAIL same_first: got write=%b wr=%0d wd=%h want 1/5/1",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    #1;
    checks++;
    if (bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_grant_b: got %b want 1", bus.b_ready);
    end
    step();
    bus.b_valid = 1'b0;
    checks++;
    if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'h2) begin
      errors++;
      $display("FAIL same_second: got write=%b wr=%0d wd=%h want 1/5/2",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.a_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.a_reg  = 5'(i + 20);
      bus.a_data = 32'(i * 32'h101);
      step();
      checks++;
      if (bus.rf_write !== 1'b1 || bus.rf_wr !== 5'(i + 20) || bus.rf_wd !== 32'(i * 32'h101)) begin
        errors++;
        $display("FAIL b2b_%0d: got write=%b wr=%0d wd=%h want 1/%0d/%h",
                 i, bus.rf_write, bus.rf_wr, bus.rf_wd, i + 20, i * 32'h101);
      end
    end
    bus.a_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd8;
    bus.a_data  = 32'h8888;
    step();
    bus.a_reg   = 5'd9;
    bus.a_data  = 32'h9999;
    reset       = 1'b1;
    #1;
    checks++;
    if (bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_a_ready: got %b want 0", bus.a_ready);
    end
    step();
    checks++;
    if (bus.rf_write !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_discard: got write=%b wr=%0d wd=%h want 0/0/0",
               bus.rf_write, bus.rf_wr, bus.rf_wd);
    end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

`ifdef RF_WB_FWD_EN
  task automatic test_forward();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd9;
    bus.a_data  = 32'hcafe;
    step();
    bus.a_valid = 1'b0;
    q1_reg      = 5'd9;
    q2_reg      = 5'd0;
    #1;
    checks++;
    if (q1_hit !== 1'b1 || q2_hit !== 1'b0 || fwd_data !== 32'hcafe) begin
      errors++;
      $display("FAIL fwd_hit: got q1=%b q2=%b data=%h want 1/0/cafe",
               q1_hit, q2_hit, fwd_data);
    end
    step();
    checks++;
    if (q1_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_idle: got q1=%b want 0", q1_hit);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
`ifdef RF_WB_FWD_EN
    q1_reg = '0;
    q2_reg = '0;
`endif
    step();
    test_reset();
    test_single_a();
    test_starvation();
    test_zero_reg();
    test_same_dest();
    test_back_to_back();
    test_reset_mid();
`ifdef RF_WB_FWD_EN
    test_forward();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
